// File: rtl/pspin_cfg_pkg.sv
// Configuration constants and command/completion types shared by the
// command scheduler and its round-robin arbiter.
package pspin_cfg_pkg;

  localparam int unsigned NUM_CLUSTERS             = 4;
  localparam int unsigned NUM_CMD_INTERFACES       = 3;
  localparam int unsigned NUM_CORES                = 8;
  localparam int unsigned NUM_HPU_CMDS             = 4;
  localparam int unsigned MAX_INFLIGHT_PER_CLUSTER = NUM_CORES * NUM_HPU_CMDS;

  localparam int unsigned CLUSTER_ID_W = $clog2(NUM_CLUSTERS);
  localparam int unsigned CORE_ID_W    = $clog2(NUM_CORES);
  localparam int unsigned HPU_CMD_W    = $clog2(NUM_HPU_CMDS);
  localparam int unsigned INTF_ID_W    = 2;

  typedef logic [$clog2(MAX_INFLIGHT_PER_CLUSTER + 1)-1:0] inflight_cnt_t;

  typedef struct packed {
    logic [CLUSTER_ID_W-1:0] cluster_id;
    logic [CORE_ID_W-1:0]    core_id;
    logic [HPU_CMD_W-1:0]    local_cmd_id;
  } pspin_cmd_id_t;

  typedef struct packed {
    pspin_cmd_id_t          cmd_id;
    logic                   generate_event;
    logic [INTF_ID_W-1:0]   intf_id;
    logic [31:0]            descr;
  } pspin_cmd_t;

  typedef struct packed {
    pspin_cmd_id_t cmd_id;
    logic [7:0]    status;
  } pspin_cmd_resp_t;

endpackage

// File: rtl/pspin_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// pointer moves past the winner only when the caller reports a handshake.
module pspin_rr_arb #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     req_i,
  input  logic             adv_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] r_ptr;
  logic [N-1:0]     w_mask;
  logic [N-1:0]     w_sel;
  logic             w_found;

  // Prefer requesters at/above the pointer, wrap to the lowest one otherwise
  always_comb begin
    w_mask  = '0;
    gnt_o   = '0;
    idx_o   = '0;
    w_found = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      w_mask[i] = (IDX_W'(i) >= r_ptr);
    end
    if ((req_i & w_mask) != '0) begin
      w_sel = req_i & w_mask;
    end else begin
      w_sel = req_i;
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!w_found && w_sel[i]) begin
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
        w_found  = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (adv_i) begin
      r_ptr <= (idx_o == IDX_W'(N - 1)) ? '0 : idx_o + IDX_W'(1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/pspin_cmd_sched.sv
// Command scheduler: RR-arbitrates cluster commands into per-interface output
// slots under a per-cluster credit limit, and routes completions back.
module pspin_cmd_sched
  import pspin_cfg_pkg::*;
#(
  parameter int unsigned N_REQ        = NUM_CLUSTERS,
  parameter int unsigned N_INTF       = NUM_CMD_INTERFACES,
  parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_PER_CLUSTER
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N_REQ-1:0]  cmd_valid_i,
  output logic [N_REQ-1:0]  cmd_ready_o,
  input  pspin_cmd_t        cmd_i [N_REQ],
  output logic [N_INTF-1:0] intf_cmd_valid_o,
  input  logic [N_INTF-1:0] intf_cmd_ready_i,
  output pspin_cmd_t        intf_cmd_o [N_INTF],
  input  logic [N_INTF-1:0] intf_resp_valid_i,
  output logic [N_INTF-1:0] intf_resp_ready_o,
  input  pspin_cmd_resp_t   intf_resp_i [N_INTF],
  output logic [N_REQ-1:0]  cmd_resp_valid_o,
  input  logic [N_REQ-1:0]  cmd_resp_ready_i,
  output pspin_cmd_resp_t   cmd_resp_o,
  output inflight_cnt_t     inflight_o [N_REQ],
  output logic              err_o
);

  localparam int unsigned REQ_IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned INTF_IDX_W = (N_INTF > 1) ? $clog2(N_INTF) : 1;
  localparam int unsigned ID_SPACE   = 2 ** INTF_ID_W;

  logic [N_INTF-1:0]     r_slot_vld;
  pspin_cmd_t            r_slot [N_INTF];
  inflight_cnt_t         r_inflight [N_REQ];
  logic                  r_err;

  logic [ID_SPACE-1:0]   w_free;
  logic [N_REQ-1:0]      w_elig;
  logic [N_REQ-1:0]      w_gnt;
  logic [REQ_IDX_W-1:0]  w_gnt_idx;
  pspin_cmd_t            w_win;
  logic                  w_acc;
  logic                  w_acc_bad;
  logic                  w_acc_good;
  logic [N_INTF-1:0]     w_rsp_gnt;
  logic [INTF_IDX_W-1:0] w_rsp_idx;
  pspin_cmd_resp_t       w_rsp;
  logic                  w_rsp_any;
  logic                  w_rsp_hs;
  logic [N_REQ-1:0]      w_rsp_vld;
  logic [N_REQ-1:0]      w_inc;
  logic [N_REQ-1:0]      w_dec;
  logic                  w_underflow;

  // Unimplemented interface ids always look free: such commands are dropped
  always_comb begin
    w_free = '1;
    for (int f = 0; f < int'(N_INTF); f++) begin
      w_free[f] = !r_slot_vld[f] || intf_cmd_ready_i[f];
    end
  end

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      w_elig[i] = cmd_valid_i[i] && (r_inflight[i] < inflight_cnt_t'(MAX_INFLIGHT)) &&
                  w_free[cmd_i[i].intf_id];
    end
  end

  pspin_rr_arb #(.N(N_REQ)) u_req_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (w_elig),
    .adv_i  (w_acc),
    .gnt_o  (w_gnt),
    .idx_o  (w_gnt_idx)
  );

  assign w_acc       = |w_elig;
  assign w_win       = cmd_i[w_gnt_idx];
  assign w_acc_bad   = w_acc && (32'(w_win.intf_id) >= N_INTF);
  assign w_acc_good  = w_acc && !w_acc_bad;
  assign cmd_ready_o = w_gnt;

  // A new command may replace a slot that drains in the same cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_slot_vld <= '0;
      for (int f = 0; f < int'(N_INTF); f++) r_slot[f] <= '0;
    end else begin
      for (int f = 0; f < int'(N_INTF); f++) begin
        if (w_acc_good && (w_win.intf_id == INTF_ID_W'(f))) begin
          r_slot_vld[f] <= 1'b1;
          r_slot[f]     <= w_win;
        end else if (intf_cmd_ready_i[f]) begin
          r_slot_vld[f] <= 1'b0;
        end else begin
          r_slot_vld[f] <= r_slot_vld[f];
        end
      end
    end
  end

  assign intf_cmd_valid_o = r_slot_vld;
  assign intf_cmd_o       = r_slot;

  pspin_rr_arb #(.N(N_INTF)) u_rsp_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (intf_resp_valid_i),
    .adv_i  (w_rsp_hs),
    .gnt_o  (w_rsp_gnt),
    .idx_o  (w_rsp_idx)
  );

  assign w_rsp_any = |intf_resp_valid_i;
  assign w_rsp     = intf_resp_i[w_rsp_idx];

  always_comb begin
    w_rsp_vld = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      w_rsp_vld[i] = w_rsp_any && (w_rsp.cmd_id.cluster_id == CLUSTER_ID_W'(i));
    end
  end

  assign w_rsp_hs          = |(w_rsp_vld & cmd_resp_ready_i);
  assign cmd_resp_valid_o  = w_rsp_vld;
  assign cmd_resp_o        = w_rsp;
  assign intf_resp_ready_o = w_rsp_gnt & {N_INTF{w_rsp_hs}};

  // A return that meets an accept in the same cycle is balanced, not an underflow
  always_comb begin
    w_inc       = w_gnt & {N_REQ{w_acc_good}};
    w_dec       = w_rsp_vld & cmd_resp_ready_i;
    w_underflow = 1'b0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (w_dec[i] && !w_inc[i] && (r_inflight[i] == '0)) begin
        w_underflow = 1'b1;
      end else begin
        w_underflow = w_underflow;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(N_REQ); i++) r_inflight[i] <= '0;
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        case ({w_inc[i], w_dec[i]})
          2'b10:   r_inflight[i] <= r_inflight[i] + inflight_cnt_t'(1);
          2'b01:   r_inflight[i] <= (r_inflight[i] == '0) ? '0 : r_inflight[i] - inflight_cnt_t'(1);
          default: r_inflight[i] <= r_inflight[i];
        endcase
      end
      r_err <= w_acc_bad || w_underflow;
    end
  end

  assign inflight_o = r_inflight;
  assign err_o      = r_err;

endmodule

// File: doc/pspin_cmd_sched.md
Name: pspin_cmd_sched

Overview:
- Central command scheduler between the HPU clusters and the command interfaces (HostDirect, NIC outbound, eDMA).
- Round-robin arbitrates pspin_cmd_t submissions from NUM_CLUSTERS requesters and enforces a per-cluster in-flight credit limit.
- Routes each winning command to the interface selected by its intf_id, through a registered output slot.
- Merges completions (pspin_cmd_resp_t) from all interfaces round-robin, routes each back to its originating cluster, and returns that cluster's credit.

Parameters:
- N_REQ, pspin_cfg_pkg::NUM_CLUSTERS, number of requesting clusters.
- N_INTF, pspin_cfg_pkg::NUM_CMD_INTERFACES, number of command interfaces.
- MAX_INFLIGHT, NUM_CORES*NUM_HPU_CMDS (32), maximum outstanding commands per cluster.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cmd_valid_i  in  N_REQ  per-cluster command valid.
- cmd_ready_o  out  N_REQ  per-cluster command accept.
- cmd_i  in  N_REQ x pspin_cmd_t  per-cluster command.
- intf_cmd_valid_o  out  N_INTF  per-interface command valid.
- intf_cmd_ready_i  in  N_INTF  per-interface ready.
- intf_cmd_o  out  N_INTF x pspin_cmd_t  registered command per interface.
- intf_resp_valid_i  in  N_INTF  completion valid.
- intf_resp_ready_o  out  N_INTF  completion accept.
- intf_resp_i  in  N_INTF x pspin_cmd_resp_t  completion.
- cmd_resp_valid_o  out  N_REQ  completion to cluster.
- cmd_resp_ready_i  in  N_REQ  cluster accepts completion.
- cmd_resp_o  out  pspin_cmd_resp_t  completion payload, shared by all clusters.
- inflight_o  out  N_REQ x clog2(MAX_INFLIGHT+1)  credit counters, for debug.
- err_o  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset: all valid/ready outputs 0, output slots empty, counters 0, RR pointers 0, err_o 0.
- Eligibility: cluster i is eligible when cmd_valid_i[i]=1, inflight[i] < MAX_INFLIGHT, and the slot for cmd_i[i].intf_id is empty or drains this cycle (valid&ready).
- Arbitration: one command accepted per cycle. Grant goes to the first eligible cluster at or after rr_req_ptr. cmd_ready_o is one-hot on the grant. Pointer advances to grant+1 (mod N_REQ) only when a grant occurs.
- Dispatch: the accepted command is written to its interface slot. intf_cmd_valid_o rises the next cycle (latency 1). The slot holds stable until intf_cmd_ready_i.
- Command with intf_id >= N_INTF is accepted and dropped. It consumes no credit and pulses err_o.
- Completion arbitration: RR over interfaces with intf_resp_valid_i. The winner drives cmd_resp_o combinationally. cmd_resp_valid_o is set only on bit resp.cmd_id.cluster_id. intf_resp_ready_o[w] = cmd_resp_ready_i[that cluster], so a completion is consumed in 0 cycles. rr_resp_ptr advances on handshake only.
- Credits: +1 on command accept, -1 on completion handshake for that cluster. Both in the same cycle for the same cluster leaves the count unchanged.
- Completion arriving at a cluster whose counter is 0 is still delivered. The counter stays at 0 and err_o pulses.
- A cluster at MAX_INFLIGHT is blocked. Its cmd_ready_o stays 0 with valid held; other clusters proceed.
- generate_event does not affect scheduling. Completion is always expected from every interface.
- A command, once valid, must not change until ready (requester obligation). The block never drops a valid slot.
- Reset mid-operation clears slots and counters. In-flight commands are forgotten; late completions then trigger err_o.

Decomposition:
- pspin_cfg_pkg gets MAX_INFLIGHT_PER_CLUSTER and the typedef inflight_cnt_t. pspin_cmd_t, pspin_cmd_resp_t and pspin_cmd_id_t are reused unchanged.
- Sub-module pspin_rr_arb (parameterised N, req vector, advance input, one-hot gnt, idx) is instantiated twice: requests and completions.

Test Plan:
- Single command, cluster 1, intf_id=2: cmd_ready_o=4'b0010 same cycle; intf_cmd_valid_o[2]=1 next cycle with identical payload; inflight_o[1]=1.
- Clusters 0-3 all valid to intf 1, intf ready always 1: grants go 0,1,2,3,0 on consecutive cycles; each cluster is served once every 4 cycles.
- Cluster 0 issues 32 commands with no completions: the 33rd is held (ready=0). One completion with cluster_id=0 frees it the following cycle; inflight returns to 32.
- intf 0 ready held low: the second command to intf 0 stalls. A concurrent command from another cluster to intf 2 is still granted.
- Completions on all 3 interfaces in the same cycle for clusters 2, 2, 3: delivered over 3 cycles in RR order; counters decrement correctly. Accept and completion for cluster 2 in the same cycle leaves its count unchanged.
- intf_id=3 command: accepted, err_o pulses 1 cycle, no slot valid, inflight unchanged. Completion to cluster with count 0: err_o pulses, counter stays 0.
